// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns onto one
// registered register-file write port, with a pending-load busy mask.
module wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int LQ_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid_i,
  input  logic [ADDR_W-1:0]        alu_addr_i,
  input  logic [DATA_W-1:0]        alu_data_i,
  output logic                     alu_ready_o,
  input  logic                     ld_valid_i,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  input  logic [DATA_W-1:0]        ld_data_i,
  output logic                     ld_ready_o,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [DATA_W-1:0]        wr_data_o,
  output logic [(1<<ADDR_W)-1:0]   busy_mask_o
);
  localparam int PW   = $clog2(LQ_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CW-1:0] FULL_C = CW'(LQ_DEPTH);

  logic [ADDR_W-1:0] lq_addr_q [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d, wr_ld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              full, empty, push, pop, alu_acc, sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   mask;
  logic [PW-1:0]     off;

  assign full  = (cnt_q == FULL_C);
  assign empty = (cnt_q == '0);

  // A full queue always drains first so a stream of ALU results cannot
  // starve loads indefinitely.
  assign pop     = full || (!alu_valid_i && !empty);
  assign alu_acc = alu_valid_i && !full;
  assign push    = ld_valid_i && !full;
  assign sel     = pop || alu_acc;

  assign sel_addr = pop ? lq_addr_q[rd_ptr_q] : alu_addr_i;
  assign sel_data = pop ? lq_data_q[rd_ptr_q] : alu_data_i;
  assign wr_en_d  = sel && (sel_addr != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    mask = '0;
    off  = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < cnt_q) mask[lq_addr_q[i]] = 1'b1;
    end
    if (wr_en_q && wr_ld_q) mask[wr_addr_q] = 1'b1;
    mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_addr_q[i] <= '0;
        lq_data_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_ld_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (push) begin
        lq_addr_q[wr_ptr_q] <= ld_addr_i;
        lq_data_q[wr_ptr_q] <= ld_data_i;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      wr_ld_q <= pop;
      if (wr_en_d) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign alu_ready_o = !full;
  assign ld_ready_o  = !full;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_mask_o = mask;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: ALU writes expected the cycle after
// acceptance, loads expected in arrival order, busy mask from queued loads.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, alu_ready, ld_ready, wr_en;
  logic [3:0]  alu_addr, ld_addr, wr_addr;
  logic [31:0] alu_data, ld_data, wr_data;
  logic [15:0] busy_mask;

  int nvec = 0;
  int nmis = 0;

  wb_arbiter #(.DATA_W(32), .ADDR_W(4), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .alu_ready_o(alu_ready),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_mask_o(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [3:0] a; logic [31:0] d; } ent_t;
  ent_t        ldq[$];
  logic        pend_alu = 1'b0;
  logic [3:0]  pa_addr;
  logic [31:0] pa_data;

  // Record handshakes as seen at the edge (pre-update ready values).
  always @(posedge clk) begin
    if (!rst_n) begin
      pend_alu = 1'b0;
      ldq.delete();
    end else begin
      pend_alu = alu_valid && alu_ready;
      pa_addr  = alu_addr;
      pa_data  = alu_data;
      if (ld_valid && ld_ready && ld_addr != 4'd0)
        ldq.push_back('{a: ld_addr, d: ld_data});
    end
  end

  always @(negedge clk) begin
    logic [15:0] em;
    ent_t e;
    if (rst_n) begin
      em = '0;
      if (pend_alu) begin
        if (pa_addr != 4'd0) begin
          chk("alu_wen",  wr_en,   1'b1);
          chk("alu_addr", wr_addr, pa_addr);
          chk("alu_data", wr_data, pa_data);
        end else
          chk("r0_alu_wen", wr_en, 1'b0);
      end else if (wr_en) begin
        if (ldq.size() == 0)
          chk("spurious_wen", wr_en, 1'b0);
        else begin
          e = ldq.pop_front();
          chk("ld_addr", wr_addr, e.a);
          chk("ld_data", wr_data, e.d);
          em[e.a] = 1'b1;
        end
      end
      foreach (ldq[i]) em[ldq[i].a] = 1'b1;
      em[0] = 1'b0;
      chk("busy_mask", busy_mask, em);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen"},  wr_en,     1'b0);
    chk({tag, "_busy"}, busy_mask, 16'h0);
    chk({tag, "_ardy"}, alu_ready, 1'b1);
    chk({tag, "_lrdy"}, ld_ready,  1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    #12;
    chk_reset_state("rst");
    chk("rst_waddr", wr_addr, 4'd0);
    chk("rst_wdata", wr_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // ALU only: one-cycle write pulse
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
    cyc(); alu_valid = 1'b0;
    chk("t_alu_wen", wr_en, 1'b1);
    chk("t_alu_addr", wr_addr, 4'd3);
    chk("t_alu_data", wr_data, 32'hDEADBEEF);
    cyc();
    chk("t_alu_pulse", wr_en, 1'b0);

    // Load latency and busy bit lifetime
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'h1234;
    cyc(); ld_valid = 1'b0;
    chk("t_ld_busy1", busy_mask[5], 1'b1);
    chk("t_ld_wen1", wr_en, 1'b0);
    cyc();
    chk("t_ld_wen2", wr_en, 1'b1);
    chk("t_ld_addr2", wr_addr, 4'd5);
    chk("t_ld_busy2", busy_mask[5], 1'b1);
    cyc();
    chk("t_ld_busy3", busy_mask[5], 1'b0);

    // Full-queue stall: head drains before the ALU
    alu_valid = 1'b1; alu_addr = 4'd8; alu_data = 32'hA8;
    ld_valid  = 1'b1; ld_addr  = 4'd6; ld_data  = 32'h66;
    cyc();
    alu_addr = 4'd9; alu_data = 32'hA9; ld_addr = 4'd7; ld_data = 32'h77;
    cyc();
    ld_valid = 1'b0; alu_addr = 4'd10; alu_data = 32'hAA;
    chk("t_full_ardy", alu_ready, 1'b0);
    chk("t_full_lrdy", ld_ready, 1'b0);
    cyc();
    chk("t_full_head", wr_addr, 4'd6);
    chk("t_full_ardy2", alu_ready, 1'b1);
    cyc();
    chk("t_full_alu", wr_addr, 4'd10);
    alu_addr = 4'd11; alu_data = 32'hAB;
    cyc(); alu_valid = 1'b0;
    cyc();
    chk("t_full_ld7", wr_addr, 4'd7);
    cyc();

    // R0 writes consumed and dropped
    alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 32'hF0;
    cyc();
    chk("t_r0_alu", wr_en, 1'b0);
    alu_addr = 4'd12; ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 32'hF1;
    cyc();
    alu_addr = 4'd13; ld_addr = 4'd1; ld_data = 32'h11;
    cyc();
    ld_valid = 1'b0; alu_addr = 4'd14;
    chk("t_r0_full", ld_ready, 1'b0);
    cyc();
    chk("t_r0_ld_wen", wr_en, 1'b0);
    chk("t_r0_popped", ld_ready, 1'b1);
    chk("t_r0_busy", busy_mask, 16'h0002);
    cyc(); alu_valid = 1'b0;
    cyc(); cyc();

    // Simultaneous push and pop: one entry resident, a write every cycle
    for (int k = 0; k < 6; k++) begin
      ld_valid = 1'b1; ld_addr = 4'(k + 1); ld_data = 32'h100 + k;
      cyc();
      chk("t_pp_lrdy", ld_ready, 1'b1);
      if (k >= 1) begin
        chk("t_pp_wen", wr_en, 1'b1);
        chk("t_pp_addr", wr_addr, 4'(k));
      end
    end
    ld_valid = 1'b0;
    cyc(); cyc();

    // Random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 300; n++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_addr  = 4'($urandom_range(0, 15));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_addr   = 4'($urandom_range(0, 15));
      ld_data   = $urandom;
      if (n == 150) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_state("mid_rst");
        idle_in();
        cyc(); cyc();
        @(negedge clk) rst_n = 1'b1;
        cyc(); cyc(); cyc();
        chk("post_rst_wen", wr_en, 1'b0);
      end else
        cyc();
    end

    idle_in();
    for (int t = 0; t < 20 && ldq.size() != 0; t++) cyc();
    cyc();
    chk("drain", ldq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
